audio_codec_config_seq: RTL and testbench
=========================================

AUDIO_CODEC_CONFIG_SEQ -- requirements
Module: audio_codec_config_seq

Interface
REQ-001 Parameter CLK_DIV, default 125: clk cycles per I2C quarter-bit tick (50 MHz -> 100 kHz SCL).
REQ-002 Parameter NUM_WORDS, default 10: configuration words per sequence (1..16).
REQ-003 Parameter DEV_ADDR, default 8'h34: codec write address byte (7-bit 0x1A, R/W=0).
REQ-004 Parameter MAX_TRIES, default 3: attempts per word before abort.
REQ-005 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-006 reset_n  in  1  reset; asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a sequence when idle.
REQ-008 cfg_idx  out  4  index of the word being requested from the external table.
REQ-009 cfg_word  in  16  table word {reg_addr[6:0], data[8:0]}; valid one cycle after cfg_idx changes.
REQ-010 scl  out  1  I2C clock.
REQ-011 sda_oe  out  1  1 = pull SDA low, 0 = release SDA (open-drain).
REQ-012 sda_i  in  1  sampled SDA line.
REQ-013 busy  out  1  high from the accepted start until DONE or ERR is reached.
REQ-014 done  out  1  one-cycle pulse when all words are acknowledged.
REQ-015 err  out  1  sticky abort flag; cleared by the next accepted start.

Function
REQ-016 A divider SHALL pulse tick every CLK_DIV cycles while busy; the divider is held at 0 when not busy.
REQ-017 The FSM states SHALL be IDLE, LOAD, START, BYTE, ACK, STOP, GAP, ERR.
REQ-018 IDLE->LOAD on start; start SHALL be ignored when busy=1.
REQ-019 LOAD SHALL wait 2 clk cycles, latch cfg_word, then go to START.
REQ-020 START: SDA released with SCL high for 1 tick, then SDA low for 1 tick, then SCL low for 1 tick.
REQ-021 Each transfer SHALL send 3 bytes MSB-first: DEV_ADDR, {reg_addr, data[8]}, data[7:0].
REQ-022 Each bit SHALL span 4 ticks: t0 SCL low and SDA set; t1 SCL high; t2 SCL high; t3 SCL low.
REQ-023 ACK SHALL release SDA for 4 ticks and sample sda_i at t2; 0 = ACK, 1 = NACK.
REQ-024 After the ACK of byte 3 the FSM SHALL enter STOP: SDA low, then SCL high, then SDA released, 1 tick each.
REQ-025 Any NACK SHALL skip the remaining bytes and enter STOP, and the attempt counter SHALL increment.
REQ-026 After STOP the FSM SHALL enter GAP and hold for 4 ticks (bus free).
REQ-027 After GAP on success: if cfg_idx==NUM_WORDS-1 the block SHALL pulse done and return to IDLE; otherwise it SHALL increment cfg_idx, clear the attempt counter, and enter LOAD.
REQ-028 After GAP on failure: if the attempt counter < MAX_TRIES the block SHALL retry the same word via LOAD; otherwise it SHALL enter ERR.
REQ-029 ERR SHALL set err=1, clear busy, and return to IDLE on the next cycle; cfg_idx SHALL hold the failing index until the next start.
REQ-030 An accepted start SHALL clear cfg_idx, the attempt counter and err in the same cycle.
REQ-031 done and err SHALL never be asserted together; busy SHALL be 0 in the cycle done pulses.
REQ-032 sda_oe SHALL change only while scl=0, except at the START and STOP edges.

Reset
REQ-033 On reset_n=0 the block SHALL asynchronously enter IDLE with: scl=1, sda_oe=0, busy=0, done=0, err=0, cfg_idx=0, divider=0, attempts=0.
REQ-034 Reset asserted mid-transfer SHALL release the bus immediately with no STOP, and the next start SHALL restart at word 0.

Verification
REQ-035 CLK_DIV=4, NUM_WORDS=2, slave always ACKs, words 16'h1E00 and 16'h0C10, start -> bytes 34,1E,00 then 34,0C,10 on SDA; done pulses once; err=0.
REQ-036 Slave NACKs the first address byte once, then ACKs -> word 0 is retried, the sequence completes with done=1 and err=0.
REQ-037 Slave NACKs all attempts on word 1 -> exactly 3 transfers of word 1; err=1; busy=0; cfg_idx=1; no done pulse.
REQ-038 start pulsed again while busy -> ignored, and the byte stream is identical to REQ-035.
REQ-039 reset_n pulled low during the second byte -> scl=1 and sda_oe=0 in the same cycle; a later start restarts at cfg_idx=0.
REQ-040 Bus monitor check on all runs: SCL high time = 2*CLK_DIV cycles, and no SDA change while SCL is high except at START/STOP.

Source files
------------

// File: rtl/audio_codec_config_seq_if.sv
// Signal bundle between the codec configuration sequencer and its environment:
// sequence handshake, table lookup and the open-drain I2C pins.
interface audio_codec_config_seq_if;
  logic        start;
  logic [3:0]  cfg_idx;
  logic [15:0] cfg_word;
  logic        scl;
  logic        sda_oe;
  logic        sda_i;
  logic        busy;
  logic        done;
  logic        err;

  // master: the sequencer (drives the I2C bus); slave: table, codec and host side
  modport master (input  start, cfg_word, sda_i,
                  output cfg_idx, scl, sda_oe, busy, done, err);
  modport slave  (output start, cfg_word, sda_i,
                  input  cfg_idx, scl, sda_oe, busy, done, err);
endinterface

// File: rtl/audio_codec_config_seq.sv
// Boot-time I2C write sequencer: streams NUM_WORDS table words to an audio codec,
// one 3-byte write per word, with per-word retry and a sticky abort flag.
module audio_codec_config_seq #(
  parameter int unsigned CLK_DIV   = 125,
  parameter int unsigned NUM_WORDS = 10,
  parameter logic [7:0]  DEV_ADDR  = 8'h34,
  parameter int unsigned MAX_TRIES = 3
) (
  input logic                      clk,
  input logic                      reset_n,
  audio_codec_config_seq_if.master bus
);
  localparam int unsigned     DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned     AW       = $clog2(MAX_TRIES + 1);
  localparam logic [DW-1:0]   DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [AW-1:0]   TRY_MAX  = AW'(MAX_TRIES);
  localparam logic [3:0]      LAST_IDX = 4'(NUM_WORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, BYTE, ACK, STOP, GAP, ERR} state_e;

  state_e        state_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    ph_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;
  logic [AW-1:0] tries_q;
  logic          ack_ok_q;
  logic          load_q;
  logic [15:0]   word_q;
  logic [7:0]    sh_q;
  logic [3:0]    idx_q;
  logic          scl_q, sda_oe_q, busy_q, done_q, err_q;
  logic          tick;
  logic [7:0]    next_byte;

  assign tick      = busy_q && (div_q == DIV_MAX);
  assign next_byte = (byte_q == 2'd0) ? word_q[15:8] : word_q[7:0];

  always_comb begin
    div_d = div_q + 1'b1;
    if (!busy_q || div_q == DIV_MAX) div_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_d;
  end

  // Every bus phase lasts one tick; outputs are updated on the tick that enters it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tries_q  <= '0;
      ack_ok_q <= 1'b0;
      load_q   <= 1'b0;
      word_q   <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, ERR: begin
          state_q <= IDLE;
          if (bus.start) begin
            state_q <= LOAD;
            load_q  <= 1'b0;
            idx_q   <= '0;
            tries_q <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        // cfg_word trails cfg_idx by one cycle, so latch on the second cycle here
        LOAD: begin
          load_q <= 1'b1;
          if (load_q) begin
            word_q   <= bus.cfg_word;
            state_q  <= START;
            ph_q     <= '0;
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
          end
        end
        START: if (tick) begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd0)      sda_oe_q <= 1'b1;
          else if (ph_q == 2'd1) scl_q    <= 1'b0;
          else begin
            state_q  <= BYTE;
            ph_q     <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            sh_q     <= {DEV_ADDR[6:0], 1'b0};
            sda_oe_q <= ~DEV_ADDR[7];
          end
        end
        BYTE: if (tick) begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd0)      scl_q <= 1'b1;
          else if (ph_q == 2'd2) scl_q <= 1'b0;
          else if (ph_q == 2'd3) begin
            if (bit_q == 3'd7) begin
              state_q  <= ACK;
              sda_oe_q <= 1'b0;
            end else begin
              bit_q    <= bit_q + 3'd1;
              sda_oe_q <= ~sh_q[7];
              sh_q     <= {sh_q[6:0], 1'b0};
            end
          end
        end
        ACK: if (tick) begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd0) scl_q <= 1'b1;
          else if (ph_q == 2'd2) begin
            scl_q    <= 1'b0;
            ack_ok_q <= ~bus.sda_i;
          end else if (ph_q == 2'd3) begin
            if (!ack_ok_q || byte_q == 2'd2) begin
              state_q  <= STOP;
              sda_oe_q <= 1'b1;
              if (!ack_ok_q) tries_q <= tries_q + 1'b1;
            end else begin
              state_q  <= BYTE;
              byte_q   <= byte_q + 2'd1;
              bit_q    <= '0;
              sh_q     <= {next_byte[6:0], 1'b0};
              sda_oe_q <= ~next_byte[7];
            end
          end
        end
        STOP: if (tick) begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd0)      scl_q    <= 1'b1;
          else if (ph_q == 2'd1) sda_oe_q <= 1'b0;
          else begin
            state_q <= GAP;
            ph_q    <= '0;
          end
        end
        GAP: if (tick) begin
          ph_q <= ph_q + 2'd1;
          if (ph_q == 2'd3) begin
            if (ack_ok_q) begin
              if (idx_q == LAST_IDX) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + 4'd1;
                tries_q <= '0;
                state_q <= LOAD;
                load_q  <= 1'b0;
              end
            end else if (tries_q < TRY_MAX) begin
              state_q <= LOAD;
              load_q  <= 1'b0;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_idx = idx_q;
  assign bus.scl     = scl_q;
  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_audio_codec_config_seq.sv
// Directed bench: models the codec table and an I2C slave, decodes the bus and
// scores decoded bytes against a queue of expected bytes.
module tb_audio_codec_config_seq;
  localparam int CLK_DIV   = 4;
  localparam int NUM_WORDS = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  audio_codec_config_seq_if bus();

  audio_codec_config_seq #(.CLK_DIV(CLK_DIV), .NUM_WORDS(NUM_WORDS),
                           .DEV_ADDR(8'h34), .MAX_TRIES(3))
    dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // external table: word valid one cycle after the index changes
  always @(posedge clk)
    case (bus.cfg_idx)
      4'd0:    bus.cfg_word <= 16'h1E00;
      4'd1:    bus.cfg_word <= 16'h0C10;
      default: bus.cfg_word <= 16'hFFFF;
    endcase

  logic       prev_scl, prev_sda, in_xfer, hi_valid, hbit, ack_dec, ack_pull;
  int         bitcnt, byte_no, xfer_no, hi_cnt, done_cnt;
  logic [7:0] shreg, nack_mask;
  logic [7:0] exp_q[$];

  assign ack_pull  = in_xfer && (bitcnt == 8) && ack_dec;
  assign bus.sda_i = ~(bus.sda_oe | ack_pull);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bus decoder, sampled on the falling clock edge
  task automatic mon();
    logic scl, sda;
    scl = bus.scl;
    sda = ~bus.sda_oe;
    if (bus.done) begin
      done_cnt++;
      chk("done_with_busy", 32'(bus.busy), 0);
      chk("done_with_err", 32'(bus.err), 0);
    end
    if (scl && prev_scl && sda != prev_sda) begin
      if (!sda) begin
        chk("start_cond_idle", 32'(in_xfer), 0);
        in_xfer = 1'b1; xfer_no++; bitcnt = 0; byte_no = 0;
      end else begin
        chk("stop_cond_aligned", {30'd0, in_xfer, bitcnt == 0}, 3);
        in_xfer = 1'b0;
      end
      hi_valid = 1'b0;
    end
    if (scl && !prev_scl) begin
      hi_cnt = 1; hi_valid = in_xfer; hbit = sda;
    end else if (scl) hi_cnt++;
    if (!scl && prev_scl && hi_valid) begin
      chk("scl_high_time", hi_cnt, 2 * CLK_DIV);
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], hbit};
        bitcnt++;
        if (bitcnt == 8) begin
          ack_dec = !(byte_no == 0 && nack_mask[xfer_no - 1]);
          if (exp_q.size() == 0) chk("byte_unexpected", {24'd0, shreg}, 32'hFFFF_FFFF);
          else chk("byte", {24'd0, shreg}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        bitcnt = 0;
        byte_no++;
      end
      hi_valid = 1'b0;
    end
    prev_scl = scl;
    prev_sda = sda;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic run_seq(input string tag, input logic [7:0] mask, input int restart_at,
                         input int exp_done, input logic exp_err, input int exp_xfers);
    int cyc;
    nack_mask = mask; xfer_no = 0; done_cnt = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, ":busy_after_start"}, 32'(bus.busy), 1);
    chk({tag, ":err_cleared"}, 32'(bus.err), 0);
    chk({tag, ":idx_cleared"}, 32'(bus.cfg_idx), 0);
    cyc = 0;
    while (bus.busy && cyc < 8000) begin
      if (cyc == restart_at) bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      cyc++;
    end
    chk({tag, ":timeout"}, 32'(bus.busy), 0);
    repeat (4) step();
    chk({tag, ":done_count"}, done_cnt, exp_done);
    chk({tag, ":err"}, 32'(bus.err), 32'(exp_err));
    chk({tag, ":cfg_idx"}, 32'(bus.cfg_idx), 1);
    chk({tag, ":xfers"}, xfer_no, exp_xfers);
    chk({tag, ":bytes_left"}, exp_q.size(), 0);
    chk({tag, ":bus_idle"}, {30'd0, bus.scl, bus.sda_oe}, 2);
  endtask

  initial begin
    int cyc;
    reset_n = 1'b0; bus.start = 1'b0;
    prev_scl = 1'b1; prev_sda = 1'b1; in_xfer = 1'b0; hi_valid = 1'b0; hbit = 1'b1;
    ack_dec = 1'b1; bitcnt = 0; byte_no = 0; xfer_no = 0; hi_cnt = 0; done_cnt = 0;
    shreg = '0; nack_mask = '0;
    repeat (3) step();
    chk("rst_scl", 32'(bus.scl), 1);
    chk("rst_sda_oe", 32'(bus.sda_oe), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_cfg_idx", 32'(bus.cfg_idx), 0);
    reset_n = 1'b1;
    repeat (2) step();

    push_bytes('{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h10});
    run_seq("all_ack", 8'h00, -1, 1, 1'b0, 2);

    push_bytes('{8'h34, 8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h10});
    run_seq("nack_once", 8'h01, -1, 1, 1'b0, 3);

    push_bytes('{8'h34, 8'h1E, 8'h00, 8'h34, 8'h34, 8'h34});
    run_seq("nack_word1", 8'h0E, -1, 0, 1'b1, 4);

    push_bytes('{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h10});
    run_seq("start_while_busy", 8'h00, 100, 1, 1'b0, 2);

    // reset in the middle of word 1's second byte
    push_bytes('{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h10});
    nack_mask = 8'h00; xfer_no = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (!(xfer_no == 2 && byte_no == 1 && bus.scl && bus.sda_oe) && cyc < 4000) begin
      step();
      cyc++;
    end
    chk("mid_reset_reached", 32'(cyc < 4000), 1);
    chk("mid_reset_idx_before", 32'(bus.cfg_idx), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_scl", 32'(bus.scl), 1);
    chk("mid_reset_sda_oe", 32'(bus.sda_oe), 0);
    chk("mid_reset_busy", 32'(bus.busy), 0);
    chk("mid_reset_cfg_idx", 32'(bus.cfg_idx), 0);
    chk("mid_reset_bytes_left", exp_q.size(), 2);
    exp_q.delete();
    in_xfer = 1'b0; bitcnt = 0; hi_valid = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();

    push_bytes('{8'h34, 8'h1E, 8'h00, 8'h34, 8'h0C, 8'h10});
    run_seq("after_reset", 8'h00, -1, 1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
